// File: rtl/time_counter.sv
// 24-hour BCD time-of-day counter with 1 Hz second pulse and display blink phase.
// Optional hour chime output enabled by defining TIME_CNT_CHIME_EN.
module time_counter #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BLINK_HZ = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_en,
   input  logic       set_load,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic [7:0] cur_hh,
   output logic [7:0] cur_mm,
   output logic [7:0] cur_ss,
   output logic       sec_p,
   output logic       blink_on
`ifdef TIME_CNT_CHIME_EN
   ,
   output logic       chime_p
`endif
);

   localparam int PW       = $clog2(CLK_HZ);
   localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Out-of-range or non-decimal fields collapse to 00 rather than loading garbage.
   function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] max_v);
      logic [7:0] r;
      if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9)) begin
         r = 8'h00;
      end else if (v > max_v) begin
         r = 8'h00;
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   logic          sec_p_q, sec_p_d;
   logic          blink_q, blink_d;
   logic          at_top;
   logic          tick;

   assign at_top = (presc_q == PRESC_MAX);
   assign tick   = at_top && !set_en && !set_load;

   // Prescaler and time registers: load beats freeze beats tick.
   always_comb begin
      presc_d = presc_q;
      hh_d    = hh_q;
      mm_d    = mm_q;
      ss_d    = ss_q;
      sec_p_d = 1'b0;
      if (set_load) begin
         presc_d = '0;
         hh_d    = bcd_clean(set_hh, 8'h23);
         mm_d    = bcd_clean(set_mm, 8'h59);
         ss_d    = bcd_clean(set_ss, 8'h59);
      end else if (set_en) begin
         presc_d = '0;
      end else if (at_top) begin
         presc_d = '0;
         sec_p_d = 1'b1;
         if (ss_q == 8'h59) begin
            ss_d = 8'h00;
            if (mm_q == 8'h59) begin
               mm_d = 8'h00;
               if (hh_q == 8'h23) begin
                  hh_d = 8'h00;
               end else begin
                  hh_d = bcd_inc(hh_q);
               end
            end else begin
               mm_d = bcd_inc(mm_q);
            end
         end else begin
            ss_d = bcd_inc(ss_q);
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Free-running blink half-period counter.
   always_comb begin
      if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
         blink_d     = blink_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q     <= '0;
         blink_cnt_q <= '0;
         hh_q        <= 8'h00;
         mm_q        <= 8'h00;
         ss_q        <= 8'h00;
         sec_p_q     <= 1'b0;
         blink_q     <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         hh_q        <= hh_d;
         mm_q        <= mm_d;
         ss_q        <= ss_d;
         sec_p_q     <= sec_p_d;
         blink_q     <= blink_d;
      end
   end

   assign cur_hh   = hh_q;
   assign cur_mm   = mm_q;
   assign cur_ss   = ss_q;
   assign sec_p    = sec_p_q;
   assign blink_on = blink_q;

`ifdef TIME_CNT_CHIME_EN
   logic chime_q, chime_d;

   // Chime only on a counted rollover into xx:00:00, never on a load.
   always_comb begin
      if (tick && (ss_q == 8'h59) && (mm_q == 8'h59)) begin
         chime_d = 1'b1;
      end else begin
         chime_d = 1'b0;
      end
   end

   // Chime output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chime_q <= 1'b0;
      end else begin
         chime_q <= chime_d;
      end
   end

   assign chime_p = chime_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter (CLK_HZ=10, BLINK_HZ=1): expected second events
// are queued by the stimulus and checked by a monitor whenever sec_p fires.
module tb_time_counter;

   localparam int CLK_HZ   = 10;
   localparam int BLINK_HZ = 1;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       set_en   = 1'b0;
   logic       set_load = 1'b0;
   logic [7:0] set_hh   = 8'h00;
   logic [7:0] set_mm   = 8'h00;
   logic [7:0] set_ss   = 8'h00;
   logic [7:0] cur_hh, cur_mm, cur_ss;
   logic       sec_p, blink_on;
`ifdef TIME_CNT_CHIME_EN
   logic       chime_p;
`endif

   int cyc    = 0;
   int n_vec  = 0;
   int n_bad  = 0;

   typedef struct {
      int          at_cyc;
      logic [23:0] t;
      logic        chime;
   } exp_t;

   exp_t exp_q[$];

   time_counter #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
      .clk      (clk),
      .rst      (rst),
      .set_en   (set_en),
      .set_load (set_load),
      .set_hh   (set_hh),
      .set_mm   (set_mm),
      .set_ss   (set_ss),
      .cur_hh   (cur_hh),
      .cur_mm   (cur_mm),
      .cur_ss   (cur_ss),
      .sec_p    (sec_p),
      .blink_on (blink_on)
`ifdef TIME_CNT_CHIME_EN
      ,
      .chime_p  (chime_p)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] now_t();
      return {cur_hh, cur_mm, cur_ss};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [23:0] t, input logic ch);
      exp_t e;
      e.at_cyc = c;
      e.t      = t;
      e.chime  = ch;
      exp_q.push_back(e);
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic [23:0] want);
      set_hh   = h;
      set_mm   = m;
      set_ss   = s;
      set_load = 1'b1;
      step(1);
      set_load = 1'b0;
      chk("load_time", now_t(), want);
      chk("load_sec_p", sec_p, 1'b0);
`ifdef TIME_CNT_CHIME_EN
      chk("load_chime", chime_p, 1'b0);
`endif
   endtask

   // Monitor: every sec_p must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && sec_p) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_sec_p: sec_p=1 at cycle %0d, required 0, time %h", cyc, now_t());
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("tick_cycle", cyc, e.at_cyc);
               chk("tick_time", now_t(), e.t);
`ifdef TIME_CNT_CHIME_EN
               chk("tick_chime", chime_p, e.chime);
`endif
            end
         end
`ifdef TIME_CNT_CHIME_EN
         else if (!rst && chime_p) begin
            n_vec++;
            n_bad++;
            $display("FAIL stray_chime: chime_p=1 without sec_p at cycle %0d, required 0", cyc);
         end
`endif
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      int l;
      step(2);
      chk("reset_time", now_t(), 24'h000000);
      chk("reset_sec_p", sec_p, 1'b0);
      chk("reset_blink", blink_on, 1'b0);

      // Free run from reset: three seconds, blink every 5 cycles.
      rst = 1'b0;
      r = cyc;
      push(r + 10, 24'h000001, 1'b0);
      push(r + 20, 24'h000002, 1'b0);
      push(r + 30, 24'h000003, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         step(1);
         chk("blink_phase", blink_on, 32'((k / 5) % 2));
      end

      // Midnight wrap.
      do_load(8'h23, 8'h59, 8'h58, 24'h235958);
      l = cyc;
      push(l + 10, 24'h235959, 1'b0);
      push(l + 20, 24'h000000, 1'b1);
      step(20);

      // Carry chains.
      do_load(8'h09, 8'h09, 8'h59, 24'h090959);
      push(cyc + 10, 24'h091000, 1'b0);
      step(10);
      do_load(8'h19, 8'h59, 8'h59, 24'h195959);
      push(cyc + 10, 24'h200000, 1'b1);
      step(10);

      // Freeze mid-second.
      step(3);
      set_en = 1'b1;
      for (int k = 0; k < 25; k++) begin
         step(1);
         chk("frozen_time", now_t(), 24'h200000);
         chk("frozen_sec_p", sec_p, 1'b0);
      end
      set_en = 1'b0;
      push(cyc + 10, 24'h200001, 1'b0);
      step(10);

      // Sanitised loads; second one collides with a tick.
      do_load(8'h24, 8'h5A, 8'h30, 24'h000030);
      step(9);
      do_load(8'h23, 8'h60, 8'h3C, 24'h230000);
      push(cyc + 10, 24'h230001, 1'b0);
      step(10);

      // Asynchronous reset mid-count.
      do_load(8'h12, 8'h34, 8'h56, 24'h123456);
      step(5);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_time", now_t(), 24'h000000);
      chk("async_rst_sec_p", sec_p, 1'b0);
      chk("async_rst_blink", blink_on, 1'b0);
      step(2);
      rst = 1'b0;
      push(cyc + 10, 24'h000001, 1'b0);
      step(10);

      step(2);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
